// File: rtl/approx_mul_rr_arbiter.sv
// Round-robin front end that time-shares one external 8x8 approximate multiplier core.
// Optional error monitor (exact-vs-core difference, saturating accumulator) under APPROX_MUL_ERR_MON_EN.
module approx_mul_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_x,
    input  logic [8*NUM_REQ-1:0] req_y,
    output logic [7:0]           mul_x,
    output logic [7:0]           mul_y,
    input  logic [15:0]          mul_z,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [15:0]          resp_z,
`ifdef APPROX_MUL_ERR_MON_EN
    output logic [15:0]          resp_err,
    output logic [23:0]          err_acc,
`endif
    output logic [CNT_W-1:0]     issue_cnt
);

    logic [7:0]       lane_x [NUM_REQ];
    logic [7:0]       lane_y [NUM_REQ];

    logic             op_valid_reg;
    logic [ID_W-1:0]  op_id_reg;
    logic [7:0]       mul_x_reg;
    logic [7:0]       mul_y_reg;
    logic             resp_valid_reg;
    logic [ID_W-1:0]  resp_id_reg;
    logic [15:0]      resp_z_reg;
    logic [CNT_W-1:0] issue_cnt_reg;
    logic [ID_W-1:0]  rr_ptr_reg;

    logic               res_load;
    logic               op_load;
    logic [NUM_REQ-1:0] grant;
    logic               grant_found;
    logic [ID_W-1:0]    grant_id;
    logic [7:0]         sel_x;
    logic [7:0]         sel_y;
    logic [ID_W-1:0]    rr_ptr_next;
    logic               accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign lane_x[gi] = req_x[8*gi +: 8];
            assign lane_y[gi] = req_y[8*gi +: 8];
        end
    endgenerate

    assign res_load = !resp_valid_reg || resp_ready;
    assign op_load  = !op_valid_reg || res_load;

    // Offset k from the pointer is tested before offset k+1, so the first hit wins.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        grant_id    = '0;
        sel_x       = '0;
        sel_y       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int target;
            target = int'(rr_ptr_reg) + k;
            if (target >= NUM_REQ) begin
                target = target - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && (target == i) && req_valid[i]) begin
                    grant_found = 1'b1;
                    grant[i]    = 1'b1;
                    grant_id    = ID_W'(i);
                    sel_x       = lane_x[i];
                    sel_y       = lane_y[i];
                end
            end
        end
    end

    always_comb begin
        rr_ptr_next = '0;
        if (int'(grant_id) != NUM_REQ - 1) begin
            rr_ptr_next = grant_id + ID_W'(1);
        end
    end

    // Ready is held low for the whole reset, not just until the first clock.
    assign req_ready = grant & {NUM_REQ{op_load && rst_n}};
    assign accept    = grant_found && op_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_reg  <= 1'b0;
            op_id_reg     <= '0;
            mul_x_reg     <= '0;
            mul_y_reg     <= '0;
            issue_cnt_reg <= '0;
            rr_ptr_reg    <= '0;
        end else if (op_load) begin
            op_valid_reg <= accept;
            if (accept) begin
                op_id_reg     <= grant_id;
                mul_x_reg     <= sel_x;
                mul_y_reg     <= sel_y;
                rr_ptr_reg    <= rr_ptr_next;
                issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_z_reg     <= '0;
        end else if (res_load) begin
            resp_valid_reg <= op_valid_reg;
            if (op_valid_reg) begin
                resp_id_reg <= op_id_reg;
                resp_z_reg  <= mul_z;
            end
        end
    end

`ifdef APPROX_MUL_ERR_MON_EN
    logic [15:0] exact_prod;
    logic [15:0] abs_err;
    logic [15:0] resp_err_reg;
    logic [23:0] err_acc_reg;
    logic [24:0] err_sum;

    assign exact_prod = {8'd0, mul_x_reg} * {8'd0, mul_y_reg};
    assign abs_err    = (exact_prod >= mul_z) ? (exact_prod - mul_z) : (mul_z - exact_prod);
    assign err_sum    = {1'b0, err_acc_reg} + {9'd0, resp_err_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_reg <= '0;
            err_acc_reg  <= '0;
        end else begin
            if (res_load && op_valid_reg) begin
                resp_err_reg <= abs_err;
            end
            // Accumulate the error of the response leaving this cycle; clamp on carry-out.
            if (resp_valid_reg && resp_ready) begin
                err_acc_reg <= err_sum[24] ? 24'hFF_FFFF : err_sum[23:0];
            end
        end
    end

    assign resp_err = resp_err_reg;
    assign err_acc  = err_acc_reg;
`endif

    assign mul_x      = mul_x_reg;
    assign mul_y      = mul_y_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_z     = resp_z_reg;
    assign issue_cnt  = issue_cnt_reg;

endmodule

// File: tb/tb_approx_mul_rr_arbiter.sv
// Directed bench for approx_mul_rr_arbiter with a behavioural multiplier core model.
// Error-monitor checks are compiled in when APPROX_MUL_ERR_MON_EN is defined.
module tb_approx_mul_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [7:0]  mul_x;
    logic [7:0]  mul_y;
    logic [15:0] mul_z;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_z;
    logic [15:0] issue_cnt;
`ifdef APPROX_MUL_ERR_MON_EN
    logic [15:0] resp_err;
    logic [23:0] err_acc;
`endif

    int checks = 0;
    int errors = 0;
    bit approx_mode = 1'b0;
    bit force_big = 1'b0;
    logic [15:0] exact_z;
    int prod [4] = '{200, 231, 264, 299};

    always #5 clk = ~clk;

    assign exact_z = {8'd0, mul_x} * {8'd0, mul_y};
    assign mul_z   = force_big ? ~exact_z : (approx_mode ? (exact_z & 16'hFFC0) : exact_z);

    approx_mul_rr_arbiter #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_z      (mul_z),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_z     (resp_z),
`ifdef APPROX_MUL_ERR_MON_EN
        .resp_err   (resp_err),
        .err_acc    (err_acc),
`endif
        .issue_cnt  (issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_n && resp_valid && resp_ready)
            $display("%0t resp id=%0d z=%0d", $time, resp_id, resp_z);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_x[8*i +: 8] = 8'(10 + i);
            req_y[8*i +: 8] = 8'(20 + i);
        end
        #2;
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_resp_z", 32'(resp_z), 32'h0);
        chk("rst_mul_x", 32'(mul_x), 32'h0);
        chk("rst_mul_y", 32'(mul_y), 32'h0);
        chk("rst_issue_cnt", 32'(issue_cnt), 32'h0);
        step();
        step();
        rst_n = 1'b1;

        // Single request: 200*150
        req_valid = 4'b0001;
        req_x[7:0] = 8'd200;
        req_y[7:0] = 8'd150;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_resp_valid0", 32'(resp_valid), 32'h0);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t1_ready_drop", 32'(req_ready), 32'h0);
        chk("t1_mul_x", 32'(mul_x), 32'd200);
        chk("t1_mul_y", 32'(mul_y), 32'd150);
        chk("t1_issue_cnt", 32'(issue_cnt), 32'd1);
        chk("t1_resp_valid_early", 32'(resp_valid), 32'h0);
        step();
        #1;
        chk("t1_resp_valid", 32'(resp_valid), 32'h1);
        chk("t1_resp_id", 32'(resp_id), 32'h0);
        chk("t1_resp_z", 32'(resp_z), 32'd30000);
        step();
        #1;
        chk("t1_resp_done", 32'(resp_valid), 32'h0);
        req_x[7:0] = 8'd10;
        req_y[7:0] = 8'd20;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // All four continuously valid: strict rotation, one response per cycle
        for (int k = 0; k < 10; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk("t2_ready", 32'(req_ready), (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
            if (k >= 2) begin
                chk("t2_resp_valid", 32'(resp_valid), 32'h1);
                chk("t2_resp_id", 32'(resp_id), 32'((k - 2) % 4));
                chk("t2_resp_z", 32'(resp_z), 32'(prod[(k - 2) % 4]));
            end else begin
                chk("t2_resp_idle", 32'(resp_valid), 32'h0);
            end
            step();
        end
        #1;
        chk("t2_issue_cnt", 32'(issue_cnt), 32'd8);
        chk("t2_resp_drained", 32'(resp_valid), 32'h0);
        step();

        // Fairness after a skip: pointer moved to 2, then only 0 and 3 request
        req_valid = 4'b0010;
        #1;
        chk("t3_ready_a", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b1001;
        #1;
        chk("t3_ready_b", 32'(req_ready), 32'h8);
        step();
        #1;
        chk("t3_ready_c", 32'(req_ready), 32'h1);
        chk("t3_resp_id_a", 32'(resp_id), 32'd1);
        chk("t3_resp_z_a", 32'(resp_z), 32'd231);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t3_resp_id_b", 32'(resp_id), 32'd3);
        chk("t3_resp_z_b", 32'(resp_z), 32'd299);
        step();
        #1;
        chk("t3_resp_id_c", 32'(resp_id), 32'd0);
        chk("t3_resp_z_c", 32'(resp_z), 32'd200);
        step();
        #1;
        chk("t3_resp_idle", 32'(resp_valid), 32'h0);
        chk("t3_issue_cnt", 32'(issue_cnt), 32'd11);
        step();

        // Stall with two products in flight
        req_valid = 4'b0110;
        #1;
        chk("t4_ready_a", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0100;
        #1;
        chk("t4_ready_b", 32'(req_ready), 32'h4);
        step();
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_stall_ready", 32'(req_ready), 32'h0);
            chk("t4_stall_valid", 32'(resp_valid), 32'h1);
            chk("t4_stall_id", 32'(resp_id), 32'd1);
            chk("t4_stall_z", 32'(resp_z), 32'd231);
            chk("t4_stall_mul_x", 32'(mul_x), 32'd12);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(req_ready), 32'h1);
        chk("t4_release_id", 32'(resp_id), 32'd1);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t4_second_valid", 32'(resp_valid), 32'h1);
        chk("t4_second_id", 32'(resp_id), 32'd2);
        chk("t4_second_z", 32'(resp_z), 32'd264);
        step();
        #1;
        chk("t4_third_id", 32'(resp_id), 32'd0);
        chk("t4_third_z", 32'(resp_z), 32'd200);
        step();
        #1;
        chk("t4_resp_idle", 32'(resp_valid), 32'h0);
        chk("t4_issue_cnt", 32'(issue_cnt), 32'd14);
        step();

        // Asynchronous reset with two products in flight
        req_valid = 4'b1111;
        #1;
        chk("t5_ready_a", 32'(req_ready), 32'h2);
        step();
        #1;
        chk("t5_ready_b", 32'(req_ready), 32'h4);
        step();
        #1;
        chk("t5_inflight", 32'(resp_valid), 32'h1);
        rst_n     = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("t5_rst_valid", 32'(resp_valid), 32'h0);
        chk("t5_rst_id", 32'(resp_id), 32'h0);
        chk("t5_rst_z", 32'(resp_z), 32'h0);
        chk("t5_rst_mul_x", 32'(mul_x), 32'h0);
        chk("t5_rst_mul_y", 32'(mul_y), 32'h0);
        chk("t5_rst_cnt", 32'(issue_cnt), 32'h0);
        chk("t5_rst_ready", 32'(req_ready), 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t5_first_grant", 32'(req_ready), 32'h2);
        step();
        req_valid = 4'b0000;
        #1;
        chk("t5_mul_x", 32'(mul_x), 32'd11);
        chk("t5_no_stale", 32'(resp_valid), 32'h0);
        chk("t5_issue_cnt", 32'(issue_cnt), 32'd1);
        step();
        #1;
        chk("t5_resp_id", 32'(resp_id), 32'd1);
        chk("t5_resp_z", 32'(resp_z), 32'd231);
        step();
        #1;
        chk("t5_resp_idle", 32'(resp_valid), 32'h0);
        step();

`ifdef APPROX_MUL_ERR_MON_EN
        // Error monitor: truncated core, then forced large errors to saturate
        approx_mode = 1'b1;
        req_x[7:0]  = 8'd255;
        req_y[7:0]  = 8'd255;
        req_valid   = 4'b0001;
        #1;
        chk("e_acc_start", 32'(err_acc), 32'h0);
        step();
        step();
        #1;
        chk("e_resp_z", 32'(resp_z), 32'hFE00);
        chk("e_resp_err", 32'(resp_err), 32'd1);
        chk("e_acc0", 32'(err_acc), 32'd0);
        step();
        req_valid = 4'b0000;
        #1;
        chk("e_acc1", 32'(err_acc), 32'd1);
        step();
        #1;
        chk("e_acc2", 32'(err_acc), 32'd2);
        step();
        #1;
        chk("e_acc3", 32'(err_acc), 32'd3);
        chk("e_resp_idle", 32'(resp_valid), 32'h0);
        force_big  = 1'b1;
        req_x[7:0] = 8'd0;
        req_y[7:0] = 8'd0;
        req_valid  = 4'b0001;
        for (int n = 0; n < 300; n++) step();
        req_valid = 4'b0000;
        step();
        step();
        step();
        #1;
        chk("e_big_err", 32'(resp_err), 32'hFFFF);
        chk("e_acc_sat", 32'(err_acc), 32'hFF_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
